// File: rtl/sa_out_requant.sv
// Requantizes 8-element rows of signed 64-bit results to int8 using a per-row
// power-of-two shift; ping-pong row buffers keep the stream stall-free.
module sa_out_requant #(
  parameter int ROW_LEN = 8,
  parameter int IN_W    = 64,
  parameter int OUT_W   = 8,
  parameter int SH_W    = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cg_en,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  in_data,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_data,
  output logic [SH_W-1:0]         out_shift,
  output logic                    out_last
);

  localparam int CNT_W = $clog2(ROW_LEN);
  localparam int MAG_W = IN_W - 1;

  logic [IN_W-1:0]  bufMem [2][ROW_LEN];
  logic             wrSel_q, wrSel_d;
  logic [CNT_W-1:0] cntIn_q, cntIn_d;
  logic [MAG_W-1:0] mag_q, mag_d;
  logic             rdSel_q, rdSel_d;
  logic [CNT_W-1:0] rdSlot_q, rdSlot_d;
  logic             rdFull_q, rdFull_d;
  logic [SH_W-1:0]  shift_q, shift_d;
  logic             outValid_q, outValid_d;
  logic [OUT_W-1:0] outData_q, outData_d;
  logic [SH_W-1:0]  outShift_q, outShift_d;
  logic             outLast_q, outLast_d;

  logic [MAG_W-1:0] magNext;
  logic [SH_W-1:0]  shNew;
  logic             rowDone;

  // Gating only saves power; the datapath behaves identically either way.
  logic unused_cg;
  assign unused_cg = cg_en;

  function automatic logic [SH_W-1:0] shiftFor(input logic [MAG_W-1:0] m);
    int nb;
    nb = 0;
    for (int i = 0; i < MAG_W; i++) begin
      if (m[i]) nb = i + 1;
    end
    return (nb > OUT_W - 1) ? SH_W'(nb - (OUT_W - 1)) : '0;
  endfunction

  function automatic logic [OUT_W-1:0] requant(input logic [IN_W-1:0] v,
                                               input logic [SH_W-1:0] sh);
    logic signed [IN_W-1:0] s;
    s = $signed(v) >>> sh;
    return s[OUT_W-1:0];
  endfunction

  assign magNext = mag_q | (in_data[MAG_W-1:0] ^ {MAG_W{in_data[IN_W-1]}});
  assign rowDone = in_valid && (cntIn_q == CNT_W'(ROW_LEN - 1));
  assign shNew   = shiftFor(magNext);

  // Row storage carries no reset; validity lives entirely in the control flops.
  always_ff @(posedge clk) begin
    if (in_valid) bufMem[wrSel_q][cntIn_q] <= in_data;
  end

  // A completing row starts emitting slot 0 on its own completion edge, so the
  // previous row is always drained before the buffers swap again.
  always_comb begin
    wrSel_d    = wrSel_q;
    cntIn_d    = cntIn_q;
    mag_d      = mag_q;
    rdSel_d    = rdSel_q;
    rdSlot_d   = rdSlot_q;
    rdFull_d   = rdFull_q;
    shift_d    = shift_q;
    outValid_d = 1'b0;
    outData_d  = '0;
    outShift_d = '0;
    outLast_d  = 1'b0;

    if (in_valid) begin
      cntIn_d = rowDone ? '0 : cntIn_q + 1'b1;
      mag_d   = rowDone ? '0 : magNext;
    end

    if (rowDone) begin
      wrSel_d    = ~wrSel_q;
      rdSel_d    = wrSel_q;
      rdFull_d   = 1'b1;
      rdSlot_d   = CNT_W'(1);
      shift_d    = shNew;
      outValid_d = 1'b1;
      outData_d  = requant(bufMem[wrSel_q][0], shNew);
      outShift_d = shNew;
    end else if (rdFull_q) begin
      outValid_d = 1'b1;
      outData_d  = requant(bufMem[rdSel_q][rdSlot_q], shift_q);
      outShift_d = shift_q;
      outLast_d  = (rdSlot_q == CNT_W'(ROW_LEN - 1));
      rdSlot_d   = rdSlot_q + 1'b1;
      if (rdSlot_q == CNT_W'(ROW_LEN - 1)) rdFull_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrSel_q    <= 1'b0;
      cntIn_q    <= '0;
      mag_q      <= '0;
      rdSel_q    <= 1'b0;
      rdSlot_q   <= '0;
      rdFull_q   <= 1'b0;
      shift_q    <= '0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outShift_q <= '0;
      outLast_q  <= 1'b0;
    end else begin
      wrSel_q    <= wrSel_d;
      cntIn_q    <= cntIn_d;
      mag_q      <= mag_d;
      rdSel_q    <= rdSel_d;
      rdSlot_q   <= rdSlot_d;
      rdFull_q   <= rdFull_d;
      shift_q    <= shift_d;
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      outShift_q <= outShift_d;
      outLast_q  <= outLast_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign out_shift = outShift_q;
  assign out_last  = outLast_q;

endmodule

// File: tb/tb_sa_out_requant.sv
// Self-checking bench for sa_out_requant: a row-level FIFO model predicts every
// output cycle, plus directed rows with hand-computed results.
module tb_sa_out_requant;

  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic [5:0] sh;
    logic       last;
  } outT;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cg_en = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [63:0] in_data = '0;
  logic               out_valid;
  logic signed [7:0]  out_data;
  logic [5:0]         out_shift;
  logic               out_last;

  int checks = 0;
  int failures = 0;

  longint rowBuf[$];
  outT    expQ[$];

  sa_out_requant dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cg_en     (cg_en),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_shift (out_shift),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  // Smallest shift that lands every element inside the int8 range.
  function automatic int refShift(input longint r[$]);
    for (int s = 0; s <= 56; s++) begin
      bit ok = 1'b1;
      foreach (r[i]) begin
        longint y = r[i] >>> s;
        if (y > 127 || y < -128) ok = 1'b0;
      end
      if (ok) return s;
    end
    return 63;
  endfunction

  function automatic longint randElem();
    longint x;
    x = {$urandom, $urandom};
    return x >>> $urandom_range(0, 63);
  endfunction

  // Drives one cycle (called at a negedge), advances the model on the rising
  // edge and samples the DUT at the following negedge.
  task automatic cycleIo(input logic v, input longint d, input logic cg,
                         output outT obs, output outT exp);
    in_valid = v;
    in_data  = d;
    cg_en    = cg;
    @(posedge clk);
    if (v) begin
      rowBuf.push_back(d);
      if (rowBuf.size() == 8) begin
        int s = refShift(rowBuf);
        for (int i = 0; i < 8; i++) begin
          outT e;
          e.v = 1'b1;
          e.d = 8'(rowBuf[i] >>> s);
          e.sh = 6'(s);
          e.last = (i == 7);
          expQ.push_back(e);
        end
        rowBuf.delete();
      end
    end
    exp = (expQ.size() > 0) ? expQ.pop_front() : '0;
    @(negedge clk);
    obs = {out_valid, out_data, out_shift, out_last};
  endtask

  task automatic resetPulse(output outT obs);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 obs = {out_valid, out_data, out_shift, out_last};
    @(negedge clk);
    rst_n = 1'b1;
    rowBuf.delete();
    expQ.delete();
  endtask

  task automatic test_reset();
    outT obs, exp;
    repeat (3) @(negedge clk);
    obs = {out_valid, out_data, out_shift, out_last};
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL reset_outputs got %h expected 0", obs);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycleIo(1'b0, 0, 1'b0, obs, exp);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL idle_after_reset got %h expected %h", obs, exp);
      end
    end
  endtask

  task automatic test_single_rows();
    longint rows[4][8];
    byte    expD[4][8];
    int     expS[4];
    outT    obs, exp;
    rows[0] = '{0, 0, 0, 0, 0, 0, 0, 0};
    rows[1] = '{127, -128, 5, -5, 0, 1, -1, 100};
    rows[2] = '{128, -129, 2, 3, -3, 0, 0, 255};
    rows[3] = '{0, 0, 0, 64'sh8000_0000_0000_0000, 0, 0, 0, 0};
    expD[0] = '{0, 0, 0, 0, 0, 0, 0, 0};
    expD[1] = '{127, -128, 5, -5, 0, 1, -1, 100};
    expD[2] = '{64, -65, 1, 1, -2, 0, 0, 127};
    expD[3] = '{0, 0, 0, -128, 0, 0, 0, 0};
    expS    = '{0, 0, 1, 56};
    for (int r = 0; r < 4; r++) begin
      int n = 0;
      int lastAt = -1;
      for (int c = 0; c < 18; c++) begin
        cycleIo(c < 8, (c < 8) ? rows[r][c] : 0, 1'b0, obs, exp);
        checks++;
        if (obs !== exp) begin
          failures++;
          $display("FAIL row%0d_cycle%0d got %h expected %h", r, c, obs, exp);
        end
        if (c == 7) begin
          checks++;
          if (obs.v !== 1'b1) begin
            failures++;
            $display("FAIL row%0d_latency got valid=%b expected 1", r, obs.v);
          end
        end
        if (obs.v === 1'b1 && n < 8) begin
          checks++;
          if (obs.d !== expD[r][n] || obs.sh !== 6'(expS[r])) begin
            failures++;
            $display("FAIL row%0d_elem%0d got d=%0d sh=%0d expected d=%0d sh=%0d",
                     r, n, $signed(obs.d), obs.sh, expD[r][n], expS[r]);
          end
          if (obs.last === 1'b1) lastAt = n;
          n++;
        end
      end
      checks++;
      if (n != 8 || lastAt != 7) begin
        failures++;
        $display("FAIL row%0d_count got n=%0d last_at=%0d expected 8 and 7", r, n, lastAt);
      end
    end
  endtask

  task automatic test_back_to_back();
    outT obs, exp;
    int  nValid = 0;
    int  nLast = 0;
    for (int c = 0; c < 75; c++) begin
      cycleIo(c < 64, (c < 64) ? randElem() : 0, 1'b1, obs, exp);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL b2b_cycle%0d got %h expected %h", c, obs, exp);
      end
      if (obs.v === 1'b1) nValid++;
      if (obs.last === 1'b1) nLast++;
      if (c >= 7 && c < 71) begin
        checks++;
        if (obs.v !== 1'b1) begin
          failures++;
          $display("FAIL b2b_gapless_cycle%0d got valid=%b expected 1", c, obs.v);
        end
      end
    end
    checks++;
    if (nValid != 64 || nLast != 8) begin
      failures++;
      $display("FAIL b2b_totals got valid=%0d last=%0d expected 64 and 8", nValid, nLast);
    end
  endtask

  task automatic test_gap_and_reset();
    outT obs, exp;
    for (int c = 0; c < 22; c++) begin
      logic v = (c < 3) || (c >= 6 && c < 11);
      cycleIo(v, v ? randElem() : 0, 1'b0, obs, exp);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL gap_cycle%0d got %h expected %h", c, obs, exp);
      end
    end
    for (int c = 0; c < 4; c++) cycleIo(1'b1, randElem(), 1'b0, obs, exp);
    resetPulse(obs);
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL midrow_reset got %h expected 0", obs);
    end
    for (int c = 0; c < 8; c++) cycleIo(1'b1, randElem(), 1'b0, obs, exp);
    for (int c = 0; c < 3; c++) cycleIo(1'b0, 0, 1'b0, obs, exp);
    resetPulse(obs);
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL midemit_reset got %h expected 0", obs);
    end
    for (int c = 0; c < 20; c++) begin
      cycleIo(c < 8, (c < 8) ? randElem() : 0, 1'b0, obs, exp);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL post_reset_cycle%0d got %h expected %h", c, obs, exp);
      end
    end
  endtask

  task automatic test_random_stream();
    outT obs, exp;
    for (int c = 0; c < 300; c++) begin
      logic v = ($urandom_range(0, 9) < 7) && (c < 285);
      cycleIo(v, v ? randElem() : 0, 1'($urandom), obs, exp);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL rand_cycle%0d got %h expected %h", c, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_rows();
    test_back_to_back();
    test_gap_and_reset();
    test_random_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sa_out_requant.md
Name: sa_out_requant

Overview:
- Downstream stage of the SA attention core.
- Consumes the serial signed 64-bit result stream (rows of 8 elements, T = 1/4/8 rows per pattern) and requantizes each row to int8 with a per-row power-of-two shift, chosen as the smallest shift that fits every element of that row.
- Ping-pong row buffering lets the block accept a continuous input stream while emitting the previous row, with no stall.

Parameters:
- ROW_LEN, 8, elements per row; a row is always complete before it is emitted.
- IN_W, 64, input data width, signed two's complement.
- OUT_W, 8, output data width, signed.
- SH_W, 6, shift field width; covers shifts 0..IN_W-OUT_W = 56.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cg_en  in  1  clock-gating enable; gating is functionally transparent, so outputs are cycle-identical for cg_en = 0 and cg_en = 1.
- in_valid  in  1  element valid; driven by the SA out_valid.
- in_data  in  IN_W  signed element; driven by the SA out_data.
- out_valid  out  1  requantized element valid.
- out_data  out  OUT_W  signed requantized element.
- out_shift  out  SH_W  shift applied to the current row; constant across the row's 8 outputs.
- out_last  out  1  high with the 8th (last) element of each row.

Behaviour:
- Reset: asynchronous on rst_n = 0.
  - All outputs go to 0.
  - Both buffers go to empty; element counters go to 0; magnitude accumulators go to 0.
  - Reset mid-row or mid-emit discards everything, and no output follows.
- Idle outputs: while out_valid = 0, out_data, out_shift and out_last are all 0.
- Collect (write buffer W):
  - Each cycle with in_valid = 1, store in_data at slot cnt_in and increment cnt_in.
  - Update the accumulator: mag |= in_data ^ {IN_W{in_data[IN_W-1]}}.
  - If in_valid drops mid-row, hold cnt_in and mag; collection resumes when in_valid returns. There is no timeout.
- Shift rule:
  - nb = index of the highest set bit of mag, plus 1; nb = 0 when mag = 0.
  - shift = max(0, nb - 7).
  - Examples: 127 -> 0; 128 -> 1; -128 -> 0; -129 -> 1; -2^63 -> 56.
- Row complete: at the edge sampling element 7 (cnt_in = 7 with in_valid = 1):
  - Latch the shift, using the accumulator value that includes element 7.
  - Mark W full, swap roles so W becomes the read buffer, and reset cnt_in and mag to 0 for the next row.
- Emit (read buffer R):
  - Starting the cycle after the row-complete edge, out_valid = 1 for 8 consecutive cycles.
  - out_data = in_data[slot] >>> shift, arithmetic shift with floor (no rounding), truncated to OUT_W. The rule guarantees no saturation is needed.
  - out_last = 1 on slot 7 only. After slot 7, R is marked empty.
- Latency: the first output element is registered, one cycle after the last input element of its row.
- Back-to-back rows:
  - A row completing at edge k emits on cycles k+1..k+8.
  - A next row arriving contiguously completes at k+8 and emits on k+9..k+16, so the output stream is gapless for gapless input.
  - Rows are never merged; each row carries its own shift.
- Simultaneous completion and emission: the row-complete edge coinciding with the emit of slot 7 of the previous row is legal; the swap happens on the same edge with no bubble.
- Overflow: input arriving at more than 1 element/cycle is impossible. With ping-pong buffering, the write buffer is always free when a row completes, so no backpressure port exists.
- Arithmetic: all shifts are signed arithmetic; the accumulator is IN_W-1 bits (sign bit excluded).

Test Plan:
- T=1, row {0 x8} -> one row out 1 cycle after last input; out_data all 0, out_shift 0, out_last on the 8th.
- Row {127,-128,5,-5,0,1,-1,100} -> shift 0, out_data identical to input.
- Row {128,-129,2,3,-3,0,0,255} -> shift 1, out = {64,-65,1,1,-2,0,0,127}.
- Row with element -2^63, others 0 -> shift 56, out_data[that slot] = -128, others 0.
- T=8, 64 contiguous inputs -> 64 contiguous out_valid cycles starting 1 cycle after input 8; 8 out_last pulses; per-row shifts match the golden model; out_data = 0 whenever out_valid = 0.
- Mid-row in_valid gap of 3 cycles, then rst_n pulsed low after input 4 of a new row -> gap row emits correctly after completion; after reset all outputs are 0, and the next 8 inputs form a fresh row.
